// File: rtl/cpu_dram_arb.sv
// Slot arbiter between refresh, video fetch and Z80 accesses; one DRAM command per 4-phase slot.
// Decision at the c3 edge; CPU read data and strobe appear in the c3 clock of the granted slot; cpu_next tells a waiting CPU whether it wins this slot.
module cpu_dram_arb #(
  parameter int VID_MAX    = 3,
  parameter int REF_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_wrbsel,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic        cpu_latch,
  output logic [15:0] cpu_rddata,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_strobe,
  output logic        dram_req,
  output logic [1:0]  dram_op,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wrdata,
  input  logic [15:0] dram_rddata
);

  localparam int RW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam int VW = (VID_MAX > 1) ? $clog2(VID_MAX + 1) : 1;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_REF,
    OWN_VID,
    OWN_CPU
  } own_t;

  own_t          r_own;
  logic [RW-1:0] r_ref_cnt;
  logic          r_ref_due;
  logic [VW-1:0] r_vid_run;
  logic          r_dram_req;
  logic [1:0]    r_dram_op;
  logic [20:0]   r_dram_addr;
  logic [1:0]    r_dram_bsel;
  logic [15:0]   r_dram_wrdata;
  logic [15:0]   r_cpu_rddata;
  logic          r_cpu_strobe;
  logic          r_cpu_latch;
  logic          r_vid_strobe;

  logic          w_vid_sat;
  own_t          w_own_nxt;

  always_comb begin
    w_vid_sat = (r_vid_run == VW'(VID_MAX));
    w_own_nxt = OWN_IDLE;
    if (r_ref_due)
      w_own_nxt = OWN_REF;
    else if (cpu_req && w_vid_sat)
      w_own_nxt = OWN_CPU;
    else if (vid_req)
      w_own_nxt = OWN_VID;
    else if (cpu_req)
      w_own_nxt = OWN_CPU;
  end

  // Equivalent to "a held cpu_req wins the next decision"; only meaningful during c3.
  assign cpu_next = !r_ref_due && (!vid_req || w_vid_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_own         <= OWN_IDLE;
      r_ref_cnt     <= RW'(REF_PERIOD - 1);
      r_ref_due     <= 1'b0;
      r_vid_run     <= '0;
      r_dram_req    <= 1'b0;
      r_dram_op     <= OP_IDLE;
      r_dram_addr   <= '0;
      r_dram_bsel   <= '0;
      r_dram_wrdata <= '0;
      r_cpu_rddata  <= '0;
      r_cpu_strobe  <= 1'b0;
      r_cpu_latch   <= 1'b0;
      r_vid_strobe  <= 1'b0;
    end else begin
      r_cpu_strobe <= 1'b0;
      r_vid_strobe <= c1 && (r_own == OWN_VID);
      if (c0)
        r_dram_req <= 1'b0;

      if (c2 && (r_own == OWN_CPU) && (r_dram_op == OP_RD)) begin
        r_cpu_rddata <= dram_rddata;
        r_cpu_strobe <= 1'b1;
        r_cpu_latch  <= 1'b1;
      end

      if (c3) begin
        r_own      <= w_own_nxt;
        r_dram_req <= (w_own_nxt != OWN_IDLE);

        unique case (w_own_nxt)
          OWN_REF: begin
            r_dram_op   <= OP_REF;
            r_dram_addr <= '0;
            r_dram_bsel <= 2'b11;
            r_ref_due   <= 1'b0;
          end
          OWN_VID: begin
            r_dram_op   <= OP_RD;
            r_dram_addr <= vid_addr;
            r_dram_bsel <= 2'b11;
          end
          OWN_CPU: begin
            r_dram_op     <= cpu_rnw ? OP_RD : OP_WR;
            r_dram_addr   <= cpu_addr;
            r_dram_bsel   <= cpu_rnw ? 2'b11 : {cpu_wrbsel, !cpu_wrbsel};
            r_dram_wrdata <= {cpu_wrdata, cpu_wrdata};
            r_cpu_latch   <= 1'b0;
          end
          default: begin
            r_dram_op <= OP_IDLE;
          end
        endcase

        // Expiry is written last so it wins over the refresh-grant clear.
        if (r_ref_cnt == '0) begin
          r_ref_cnt <= RW'(REF_PERIOD - 1);
          r_ref_due <= 1'b1;
        end else begin
          r_ref_cnt <= r_ref_cnt - RW'(1);
        end

        if ((w_own_nxt == OWN_CPU) || !cpu_req)
          r_vid_run <= '0;
        else if ((w_own_nxt == OWN_VID) && !w_vid_sat)
          r_vid_run <= r_vid_run + VW'(1);
      end
    end
  end

  assign dram_req    = r_dram_req;
  assign dram_op     = r_dram_op;
  assign dram_addr   = r_dram_addr;
  assign dram_bsel   = r_dram_bsel;
  assign dram_wrdata = r_dram_wrdata;
  assign cpu_rddata  = r_cpu_rddata;
  assign cpu_strobe  = r_cpu_strobe;
  assign cpu_latch   = r_cpu_latch;
  assign vid_strobe  = r_vid_strobe;

endmodule

// File: tb/tb_cpu_dram_arb.sv
// Directed bench for cpu_dram_arb: default instance plus a REF_PERIOD=4 instance on shared inputs.
module tb_cpu_dram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ph = 2'd0;
  logic        c0, c1, c2, c3;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [20:0] cpu_addr = '0;
  logic        cpu_wrbsel = 1'b0;
  logic [7:0]  cpu_wrdata = '0;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = '0;
  logic [15:0] dram_rddata = '0;

  logic        cpu_next, cpu_strobe, cpu_latch, vid_strobe, dram_req;
  logic [15:0] cpu_rddata, dram_wrdata;
  logic [1:0]  dram_op, dram_bsel;
  logic [20:0] dram_addr;

  logic        r4_cpu_next, r4_cpu_strobe, r4_cpu_latch, r4_vid_strobe, r4_dram_req;
  logic [15:0] r4_cpu_rddata, r4_dram_wrdata;
  logic [1:0]  r4_dram_op, r4_dram_bsel;
  logic [20:0] r4_dram_addr;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign c0 = (ph == 2'd0);
  assign c1 = (ph == 2'd1);
  assign c2 = (ph == 2'd2);
  assign c3 = (ph == 2'd3);

  cpu_dram_arb u_dut (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
    .cpu_rddata(cpu_rddata), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_strobe(vid_strobe), .dram_req(dram_req), .dram_op(dram_op),
    .dram_addr(dram_addr), .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata),
    .dram_rddata(dram_rddata)
  );

  cpu_dram_arb #(.VID_MAX(3), .REF_PERIOD(4)) u_ref4 (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata),
    .cpu_next(r4_cpu_next), .cpu_strobe(r4_cpu_strobe), .cpu_latch(r4_cpu_latch),
    .cpu_rddata(r4_cpu_rddata), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_strobe(r4_vid_strobe), .dram_req(r4_dram_req), .dram_op(r4_dram_op),
    .dram_addr(r4_dram_addr), .dram_bsel(r4_dram_bsel), .dram_wrdata(r4_dram_wrdata),
    .dram_rddata(dram_rddata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Return at the falling edge inside the next clock whose phase is k.
  task automatic wait_ph(input int k);
    do @(negedge clk); while (ph != 2'(k));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    wait_ph(0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_strobe", 32'(cpu_strobe), 32'd0);
    chk("rst_latch", 32'(cpu_latch), 32'd0);
    chk("rst_vstrobe", 32'(vid_strobe), 32'd0);
    chk("rst_dreq", 32'(dram_req), 32'd0);
    chk("rst_op", 32'(dram_op), 32'd0);
    chk("rst_addr", 32'(dram_addr), 32'd0);
    chk("rst_bsel", 32'(dram_bsel), 32'd0);
    chk("rst_wdat", 32'(dram_wrdata), 32'd0);
    chk("rst_rdat", 32'(cpu_rddata), 32'd0);
    chk("rst_next_novid", 32'(cpu_next), 32'd1);
    vid_req = 1'b1;
    #1 chk("rst_next_vid", 32'(cpu_next), 32'd0);
    vid_req = 1'b0;
    wait_ph(0);
    rst = 1'b0;

    // CPU read on an idle bus
    wait_ph(3);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h012345;
    #1 chk("rd_next", 32'(cpu_next), 32'd1);
    wait_ph(0);
    chk("rd_dreq", 32'(dram_req), 32'd1);
    chk("rd_op", 32'(dram_op), 32'd1);
    chk("rd_addr", 32'(dram_addr), 32'h012345);
    chk("rd_bsel", 32'(dram_bsel), 32'd3);
    cpu_req = 1'b0;
    wait_ph(1);
    chk("rd_dreq_c1", 32'(dram_req), 32'd0);
    chk("rd_op_c1", 32'(dram_op), 32'd1);
    wait_ph(2);
    dram_rddata = 16'hBEEF;
    chk("rd_strobe_c2", 32'(cpu_strobe), 32'd0);
    wait_ph(3);
    dram_rddata = 16'h0000;
    chk("rd_strobe", 32'(cpu_strobe), 32'd1);
    chk("rd_data", 32'(cpu_rddata), 32'hBEEF);
    chk("rd_latch", 32'(cpu_latch), 32'd1);
    wait_ph(0);
    chk("rd_strobe_off", 32'(cpu_strobe), 32'd0);
    chk("idle_op", 32'(dram_op), 32'd0);
    chk("idle_dreq", 32'(dram_req), 32'd0);
    chk("rd_latch_hold", 32'(cpu_latch), 32'd1);

    // CPU write high byte; clears the latch
    wait_ph(3);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_wrbsel = 1'b1; cpu_wrdata = 8'hA5;
    cpu_addr = 21'h000100;
    #1 chk("wr_next", 32'(cpu_next), 32'd1);
    chk("wr_latch_pre", 32'(cpu_latch), 32'd1);
    wait_ph(0);
    cpu_req = 1'b0;
    chk("wr_dreq", 32'(dram_req), 32'd1);
    chk("wr_op", 32'(dram_op), 32'd2);
    chk("wr_bsel", 32'(dram_bsel), 32'd2);
    chk("wr_wdat", 32'(dram_wrdata), 32'hA5A5);
    chk("wr_addr", 32'(dram_addr), 32'h000100);
    chk("wr_latch", 32'(cpu_latch), 32'd0);
    wait_ph(3);
    chk("wr_nostrobe", 32'(cpu_strobe), 32'd0);
    chk("wr_rdat_keep", 32'(cpu_rddata), 32'hBEEF);

    // Video vs CPU: V,V,V,C repeating
    do_reset();
    vid_req = 1'b1; vid_addr = 21'h1ABCDE;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h000777;
    for (int s = 0; s < 8; s++) begin
      wait_ph(3);
      chk($sformatf("vc_next%0d", s), 32'(cpu_next), 32'((s % 4) == 3));
      if (s > 0)
        chk($sformatf("vc_strobe%0d", s), 32'(cpu_strobe), 32'(((s - 1) % 4) == 3));
      wait_ph(0);
      chk($sformatf("vc_addr%0d", s), 32'(dram_addr),
          ((s % 4) == 3) ? 32'h000777 : 32'h1ABCDE);
      chk($sformatf("vc_op%0d", s), 32'(dram_op), 32'd1);
      wait_ph(2);
      chk($sformatf("vc_vstrobe%0d", s), 32'(vid_strobe), 32'((s % 4) != 3));
    end
    vid_req = 1'b0; cpu_req = 1'b0;

    // Refresh every 4th slot under continuous CPU reads (REF_PERIOD=4 instance)
    do_reset();
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h000042;
    for (int k = 1; k <= 10; k++) begin
      wait_ph(3);
      chk($sformatf("ref_next%0d", k), 32'(r4_cpu_next),
          32'(!((k >= 5) && (((k - 5) % 4) == 0))));
      wait_ph(0);
      chk($sformatf("ref_op%0d", k), 32'(r4_dram_op),
          ((k >= 5) && (((k - 5) % 4) == 0)) ? 32'd3 : 32'd1);
    end
    cpu_req = 1'b0;

    // Reset in the c1 clock of a CPU read slot
    do_reset();
    wait_ph(3);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0ABCDE;
    wait_ph(0);
    cpu_req = 1'b0;
    chk("mr_dreq", 32'(dram_req), 32'd1);
    wait_ph(1);
    rst = 1'b1;
    dram_rddata = 16'h1234;
    wait_ph(2);
    rst = 1'b0;
    chk("mr_op", 32'(dram_op), 32'd0);
    chk("mr_addr", 32'(dram_addr), 32'd0);
    chk("mr_bsel", 32'(dram_bsel), 32'd0);
    chk("mr_dreq0", 32'(dram_req), 32'd0);
    chk("mr_rdat", 32'(cpu_rddata), 32'd0);
    wait_ph(3);
    chk("mr_nostrobe", 32'(cpu_strobe), 32'd0);
    chk("mr_rdat_keep", 32'(cpu_rddata), 32'd0);
    cpu_req = 1'b1; cpu_addr = 21'h000055;
    wait_ph(0);
    cpu_req = 1'b0;
    dram_rddata = 16'h0000;
    chk("mr_regrant", 32'(dram_req), 32'd1);
    chk("mr_regrant_addr", 32'(dram_addr), 32'h000055);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
